// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: widths, default halt opcode
// and the fetch FSM state type.
package inst_fetch_queue_pkg;
  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;
endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Synchronous FIFO with push/pop/flush; pointers wrap modulo DEPTH (power of 2).
// Flush has priority over push and pop in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: reads the ROM one word per cycle into a small queue
// drained by issue; handles back-pressure, redirects and halt.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned ROM_BYTES = 100,
  parameter logic [5:0]  HALT_OP   = HALT_OP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   nrst,
  output logic                   rom_nrd,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [INST_W-1:0]      rom_data,
  input  logic                   redir_valid,
  input  logic [ADDR_W-1:0]      redir_pc,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [INST_W-1:0]      deq_inst,
  output logic [ADDR_W-1:0]      deq_pc,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   halted
);
  state_t                     state, state_nx;
  logic [ADDR_W-1:0]          pc, pc_nx;
  logic [INST_W+ADDR_W-1:0]   fifo_dout;
  logic                       fifo_full, fifo_empty;
  logic                       deq_fire, space, in_rom, fetch;

  assign deq_valid = ~fifo_empty;
  assign deq_fire  = deq_valid & deq_ready;
  assign space     = ~fifo_full | deq_fire;
  assign in_rom    = ({1'b0, pc} + 33'd4) <= 33'(ROM_BYTES);
  // Gating with nrst keeps the strobe inactive while reset is held.
  assign fetch     = nrst & (state == FETCH) & space & in_rom & ~redir_valid;

  assign rom_nrd   = ~fetch;
  assign rom_addr  = pc;
  assign deq_inst  = deq_valid ? fifo_dout[INST_W+ADDR_W-1:ADDR_W] : '0;
  assign deq_pc    = deq_valid ? fifo_dout[ADDR_W-1:0] : '0;
  assign halted    = (state == HALT);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (redir_valid) begin
      state_nx = FETCH;
      pc_nx    = redir_pc & ~32'h3;
    end else begin
      if (fetch) pc_nx = pc + 32'd4;
      if (state == FETCH && (!in_rom || (fetch && rom_data[31:26] == HALT_OP)))
        state_nx = HALT;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  sync_fifo #(
    .WIDTH(INST_W + ADDR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .nrst (nrst),
    .push (fetch),
    .pop  (deq_fire & ~redir_valid),
    .flush(redir_valid),
    .din  ({rom_data, pc}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(q_count)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: cycle table for back-pressure/redirect, scoreboard
// of fetched words against dequeued entries, and halt/end-of-ROM/reset sequences.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NWORDS = 25;

  logic        clk = 1'b0;
  logic        nrst;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  q_count;
  logic        halted;

  logic [31:0] rom [NWORDS];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx < int'(NWORDS)) return rom[idx];
    return 32'hDEADBEEF;
  endfunction

  // Non-fetch cycles return garbage so any capture outside a strobe shows up.
  assign rom_data = rom_nrd ? 32'hDEADBEEF : rom_rd(rom_addr);

  inst_fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0),
    .ROM_BYTES(100),
    .HALT_OP(6'b111111)
  ) dut (
    .clk(clk), .nrst(nrst), .rom_nrd(rom_nrd), .rom_addr(rom_addr),
    .rom_data(rom_data), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .q_count(q_count), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t sb[$];

  always @(negedge clk) begin
    ent_t e;
    if (!nrst) begin
      sb.delete();
    end else begin
      chk("sb_count", 32'(q_count), 32'(sb.size()));
      if (redir_valid) begin
        sb.delete();
      end else begin
        if (deq_valid && deq_ready) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_deq", 32'(deq_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("sb_deq_inst", deq_inst, e.inst);
            chk("sb_deq_pc", deq_pc, e.pc);
          end
        end
        if (!rom_nrd) sb.push_back('{inst: rom_data, pc: rom_addr});
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        nrd;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic        dv;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic nrd, input logic [31:0] addr, input logic [2:0] cnt,
                              input logic dv, input logic [31:0] inst, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.nrd = nrd; v.addr = addr;
    v.cnt = cnt; v.dv = dv; v.inst = inst; v.pc = pc;
    return v;
  endfunction

  task automatic fill_rom();
    for (int unsigned i = 0; i < NWORDS; i++) rom[i] = 32'h0A000000 | 32'(i);
    rom[0] = 32'h11111111;
    rom[1] = 32'h22222222;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    deq_ready = 1'b0;
    redir_valid = 1'b0;
    redir_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_nrd", 32'(rom_nrd), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_deq_inst", deq_inst, 32'd0);
    chk("rst_deq_pc", deq_pc, 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    step();
    nrst = 1'b1;
  endtask

  vec_t tbl [21];
  logic [31:0] last_fetch;
  int fetches;

  initial begin
    tbl[0]  = mk(0, 0, 32'h0,  0, 32'h00, 0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,  0, 32'h04, 1, 1, 32'h11111111, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,  0, 32'h08, 2, 1, 32'h11111111, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,  0, 32'h0C, 3, 1, 32'h11111111, 32'h0);
    for (int i = 4; i < 10; i++)
      tbl[i] = mk(0, 0, 32'h0, 1, 32'h10, 4, 1, 32'h11111111, 32'h0);
    tbl[10] = mk(1, 0, 32'h0,  0, 32'h10, 4, 1, 32'h11111111, 32'h0);
    tbl[11] = mk(1, 0, 32'h0,  0, 32'h14, 4, 1, 32'h22222222, 32'h4);
    tbl[12] = mk(1, 0, 32'h0,  0, 32'h18, 4, 1, 32'h0A000002, 32'h8);
    tbl[13] = mk(0, 1, 32'h40, 1, 32'h1C, 4, 1, 32'h0A000003, 32'hC);
    tbl[14] = mk(0, 0, 32'h0,  0, 32'h40, 0, 0, 32'h0, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,  0, 32'h44, 1, 1, 32'h0A000010, 32'h40);
    tbl[16] = mk(0, 0, 32'h0,  0, 32'h48, 2, 1, 32'h0A000010, 32'h40);
    tbl[17] = mk(1, 1, 32'h22, 1, 32'h4C, 3, 1, 32'h0A000010, 32'h40);
    tbl[18] = mk(1, 0, 32'h0,  0, 32'h20, 0, 0, 32'h0, 32'h0);
    tbl[19] = mk(1, 0, 32'h0,  0, 32'h24, 1, 1, 32'h0A000008, 32'h20);
    tbl[20] = mk(0, 0, 32'h0,  0, 32'h28, 1, 1, 32'h0A000009, 32'h24);

    // Back-pressure, full-queue streaming and redirect table.
    fill_rom();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      deq_ready   = tbl[i].rdy;
      redir_valid = tbl[i].rv;
      redir_pc    = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("t%0d_nrd", i), 32'(rom_nrd), 32'(tbl[i].nrd));
      chk($sformatf("t%0d_addr", i), rom_addr, tbl[i].addr);
      chk($sformatf("t%0d_count", i), 32'(q_count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_valid", i), 32'(deq_valid), 32'(tbl[i].dv));
      chk($sformatf("t%0d_inst", i), deq_inst, tbl[i].inst);
      chk($sformatf("t%0d_pc", i), deq_pc, tbl[i].pc);
      chk($sformatf("t%0d_halted", i), 32'(halted), 32'd0);
      step();
    end
    redir_valid = 1'b0;

    // Halt opcode at address 8, drain, then redirect back to 0.
    fill_rom();
    rom[2] = 32'hFC000000;
    do_reset();
    repeat (3) step();
    @(negedge clk);
    chk("halt_state", 32'(halted), 32'd1);
    chk("halt_nrd", 32'(rom_nrd), 32'd1);
    chk("halt_addr", rom_addr, 32'hC);
    chk("halt_count", 32'(q_count), 32'd3);
    step();
    deq_ready = 1'b1;
    for (int i = 0; i < 8 && q_count != 0; i++) begin
      @(negedge clk);
      chk("halt_drain_nrd", 32'(rom_nrd), 32'd1);
      step();
    end
    @(negedge clk);
    chk("halt_empty_count", 32'(q_count), 32'd0);
    chk("halt_empty_valid", 32'(deq_valid), 32'd0);
    chk("halt_still", 32'(halted), 32'd1);
    step();
    redir_valid = 1'b1;
    redir_pc = 32'h0;
    step();
    redir_valid = 1'b0;
    @(negedge clk);
    chk("unhalt_state", 32'(halted), 32'd0);
    chk("unhalt_nrd", 32'(rom_nrd), 32'd0);
    chk("unhalt_addr", rom_addr, 32'h0);
    step();

    // Run to the end of a 100-byte ROM.
    fill_rom();
    do_reset();
    deq_ready = 1'b1;
    last_fetch = 32'hFFFFFFFF;
    fetches = 0;
    for (int i = 0; i < 60 && !halted; i++) begin
      @(negedge clk);
      if (!rom_nrd) begin
        last_fetch = rom_addr;
        fetches++;
      end
      step();
    end
    chk("eor_halted", 32'(halted), 32'd1);
    chk("eor_last_fetch", last_fetch, 32'd96);
    chk("eor_fetch_count", 32'(fetches), 32'd25);
    @(negedge clk);
    chk("eor_addr", rom_addr, 32'd100);
    chk("eor_nrd", 32'(rom_nrd), 32'd1);
    step();

    // Asynchronous reset with two entries queued.
    fill_rom();
    do_reset();
    repeat (2) step();
    @(negedge clk);
    chk("mid_count_before", 32'(q_count), 32'd2);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_nrd", 32'(rom_nrd), 32'd1);
    chk("async_valid", 32'(deq_valid), 32'd0);
    chk("async_count", 32'(q_count), 32'd0);
    chk("async_inst", deq_inst, 32'd0);
    chk("async_pc", deq_pc, 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("post_rst_addr", rom_addr, 32'h0);
    chk("post_rst_count", 32'(q_count), 32'd0);
    chk("post_rst_nrd", 32'(rom_nrd), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
